// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V controller: a Moore FSM that steps each instruction through
// FETCH/DECODE/execute states and drives every datapath select and write enable.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       Zero,
  input  logic       ALUResult_sign,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic [3:0] fsm_state
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALR2    = 4'd12,
    S_LUI      = 4'd13
  } state_t;

  state_t state, state_next;
  logic [2:0] alu_fn;
  logic       taken;
  logic       unused_func7;

  // Only func7[5] (sub vs add) matters to this controller.
  assign unused_func7 = ^{func7[6], func7[4:0]};
  assign fsm_state    = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_next;
  end

  always_comb begin
    alu_fn = ALU_ADD;
    case (func3)
      3'b000:  alu_fn = (op == OP_R && func7[5]) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_fn = ALU_AND;
      3'b110:  alu_fn = ALU_OR;
      3'b010:  alu_fn = ALU_SLT;
      default: alu_fn = ALU_ADD;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (func3)
      3'b000:  taken = Zero;
      3'b001:  taken = !Zero;
      3'b100:  taken = ALUResult_sign;
      3'b101:  taken = !ALUResult_sign;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_BR:        state_next = S_BRANCH;
          OP_JAL:       state_next = S_JAL;
          OP_JALR:      state_next = S_JALR;
          OP_LUI:       state_next = S_LUI;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = S_FETCH;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      S_JALR:     state_next = S_JALR2;
      S_JALR2:    state_next = S_ALUWB;
      S_LUI:      state_next = S_FETCH;
      default:    state_next = S_FETCH;
    endcase
  end

  // Outputs are held at zero while reset is low, even though the state is FETCH.
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    ImmSrc     = 3'b000;
    if (rst) begin
      case (state)
        S_FETCH: begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
        end
        S_DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          ImmSrc  = (op == OP_JAL) ? 3'b011 : 3'b010;
        end
        S_MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ImmSrc  = (op == OP_SW) ? 3'b001 : 3'b000;
        end
        S_MEMREAD: begin
          AdrSrc = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
        end
        S_MEMWRITE: begin
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
        end
        S_EXECR: begin
          ALUSrcA    = 2'b10;
          ALUControl = alu_fn;
        end
        S_EXECI: begin
          ALUSrcA    = 2'b10;
          ALUSrcB    = 2'b01;
          ALUControl = alu_fn;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA    = 2'b10;
          ALUControl = ALU_SUB;
          PCWrite    = taken;
        end
        S_JAL, S_JALR2: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          PCWrite = 1'b1;
        end
        S_JALR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
        end
        S_LUI: begin
          ImmSrc    = 3'b100;
          ResultSrc = 2'b11;
          RegWrite  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction cycle sequences are built from the
// instruction's semantics and compared cycle by cycle against the controller outputs.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       Zero;
  logic       ALUResult_sign;
  logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
  logic [3:0] fsm_state;

  logic [18:0] obs;
  logic [18:0] exp_q[$];
  logic [18:0] obs_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
    .Zero(Zero), .ALUResult_sign(ALUResult_sign),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  assign obs = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc};

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [18:0] v(input logic pcw, adr, irw, mw, rw,
                                    input logic [1:0] rs, sa, sb,
                                    input logic [2:0] alu, imm);
    return {pcw, adr, irw, mw, rw, rs, sa, sb, alu, imm};
  endfunction

  function automatic logic [2:0] alu_op(input logic [6:0] o, input logic [2:0] f3,
                                        input logic [6:0] f7);
    if (f3 == 3'b000) return (o == 7'b0110011 && f7[5]) ? 3'b001 : 3'b000;
    if (f3 == 3'b111) return 3'b010;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b010) return 3'b101;
    return 3'b000;
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic s);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return s;
      3'b101:  return !s;
      default: return 1'b0;
    endcase
  endfunction

  // Expected output vector for every cycle of one instruction, FETCH first.
  task automatic build_expected(input logic [6:0] o, input logic [2:0] f3,
                                input logic [6:0] f7, input logic z, input logic s);
    logic [18:0] wb;
    wb = v(0,0,0,0,1, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0);
    exp_q.push_back(v(1,0,1,0,0, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0));
    exp_q.push_back(v(0,0,0,0,0, 2'd0, 2'd1, 2'd1, 3'd0, (o == 7'b1101111) ? 3'd3 : 3'd2));
    case (o)
      7'b0000011: begin
        exp_q.push_back(v(0,0,0,0,0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0));
        exp_q.push_back(v(0,1,0,0,0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0));
        exp_q.push_back(v(0,0,0,0,1, 2'd1, 2'd0, 2'd0, 3'd0, 3'd0));
      end
      7'b0100011: begin
        exp_q.push_back(v(0,0,0,0,0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd1));
        exp_q.push_back(v(0,1,0,1,0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0));
      end
      7'b0110011: begin
        exp_q.push_back(v(0,0,0,0,0, 2'd0, 2'd2, 2'd0, alu_op(o, f3, f7), 3'd0));
        exp_q.push_back(wb);
      end
      7'b0010011: begin
        exp_q.push_back(v(0,0,0,0,0, 2'd0, 2'd2, 2'd1, alu_op(o, f3, f7), 3'd0));
        exp_q.push_back(wb);
      end
      7'b1100011:
        exp_q.push_back(v(br_taken(f3, z, s),0,0,0,0, 2'd0, 2'd2, 2'd0, 3'd1, 3'd0));
      7'b1101111: begin
        exp_q.push_back(v(1,0,0,0,0, 2'd0, 2'd1, 2'd2, 3'd0, 3'd0));
        exp_q.push_back(wb);
      end
      7'b1100111: begin
        exp_q.push_back(v(0,0,0,0,0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0));
        exp_q.push_back(v(1,0,0,0,0, 2'd0, 2'd1, 2'd2, 3'd0, 3'd0));
        exp_q.push_back(wb);
      end
      7'b0110111:
        exp_q.push_back(v(0,0,0,0,1, 2'd3, 2'd0, 2'd0, 3'd0, 3'd4));
      default: ;
    endcase
  endtask

  // ---------------- driver ----------------
  // Starts in a FETCH cycle just after a rising edge; records one output vector per cycle.
  task automatic drive_instr(input logic [6:0] o, input logic [2:0] f3,
                             input logic [6:0] f7, input logic z, input logic s);
    int n;
    op = o; func3 = f3; func7 = f7; Zero = z; ALUResult_sign = s;
    exp_q.delete();
    obs_q.delete();
    build_expected(o, f3, f7, z, s);
    n = exp_q.size();
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      obs_q.push_back(obs);
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [6:0] rand_legal_op();
    case ($urandom_range(0, 7))
      0: return 7'b0000011;
      1: return 7'b0100011;
      2: return 7'b0110011;
      3: return 7'b0010011;
      4: return 7'b1100011;
      5: return 7'b1101111;
      6: return 7'b1100111;
      default: return 7'b0110111;
    endcase
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      op = 7'($urandom); func3 = 3'($urandom); func7 = 7'($urandom);
      Zero = 1'($urandom); ALUResult_sign = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if (obs !== 19'h0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc%0d obs=%h exp=%h", c, obs, 19'h0);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    n_checks++;
    if (obs !== v(1,0,1,0,0, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0)) begin
      n_fail++;
      $display("FAIL reset_first_fetch obs=%h exp=%h", obs, v(1,0,1,0,0, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0));
    end
  endtask

  task automatic test_alu();
    logic [18:0] e, o;
    for (int i = 0; i < 40; i++) begin
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      if (i == 0)      begin opc = 7'b0110011; f3 = 3'b000; f7 = 7'b0000000; end
      else if (i == 1) begin opc = 7'b0110011; f3 = 3'b000; f7 = 7'b0100000; end
      else if (i == 2) begin opc = 7'b0010011; f3 = 3'b000; f7 = 7'b0100000; end
      else begin
        opc = $urandom_range(0, 1) ? 7'b0110011 : 7'b0010011;
        f3 = 3'($urandom); f7 = 7'($urandom);
      end
      drive_instr(opc, f3, f7, 1'($urandom), 1'($urandom));
      for (int c = 0; exp_q.size() > 0; c++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_checks++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL alu op=%b f3=%b f7=%b cyc%0d obs=%h exp=%h", opc, f3, f7, c + 1, o, e);
        end
      end
    end
  endtask

  task automatic test_mem();
    logic [18:0] e, o;
    for (int i = 0; i < 10; i++) begin
      logic [6:0] opc;
      opc = i[0] ? 7'b0100011 : 7'b0000011;
      drive_instr(opc, 3'b010, 7'($urandom), 1'($urandom), 1'($urandom));
      for (int c = 0; exp_q.size() > 0; c++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_checks++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL mem op=%b cyc%0d obs=%h exp=%h", opc, c + 1, o, e);
        end
      end
    end
  endtask

  task automatic test_branch();
    logic [18:0] e, o;
    for (int i = 0; i < 40; i++) begin
      logic [2:0] f3;
      logic z, s;
      case (i)
        0: begin f3 = 3'b000; z = 1; s = 0; end
        1: begin f3 = 3'b001; z = 1; s = 0; end
        2: begin f3 = 3'b100; z = 0; s = 1; end
        3: begin f3 = 3'b101; z = 0; s = 1; end
        default: begin f3 = 3'($urandom); z = 1'($urandom); s = 1'($urandom); end
      endcase
      drive_instr(7'b1100011, f3, 7'($urandom), z, s);
      for (int c = 0; exp_q.size() > 0; c++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_checks++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL branch f3=%b z=%b s=%b cyc%0d obs=%h exp=%h", f3, z, s, c + 1, o, e);
        end
      end
    end
  endtask

  task automatic test_jumps();
    logic [18:0] e, o;
    for (int i = 0; i < 12; i++) begin
      logic [6:0] opc;
      case (i % 3)
        0:       opc = 7'b1101111;
        1:       opc = 7'b1100111;
        default: opc = 7'b0110111;
      endcase
      drive_instr(opc, 3'($urandom), 7'($urandom), 1'($urandom), 1'($urandom));
      for (int c = 0; exp_q.size() > 0; c++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_checks++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL jump op=%b cyc%0d obs=%h exp=%h", opc, c + 1, o, e);
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic [18:0] e, o;
    for (int i = 0; i < 10; i++) begin
      logic [6:0] opc;
      if (i == 0) opc = 7'b1111111;
      else begin
        opc = 7'($urandom);
        while (opc == 7'b0000011 || opc == 7'b0100011 || opc == 7'b0110011 ||
               opc == 7'b0010011 || opc == 7'b1100011 || opc == 7'b1101111 ||
               opc == 7'b1100111 || opc == 7'b0110111)
          opc = 7'($urandom);
      end
      drive_instr(opc, 3'($urandom), 7'($urandom), 1'($urandom), 1'($urandom));
      for (int c = 0; exp_q.size() > 0; c++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_checks++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL illegal op=%b cyc%0d obs=%h exp=%h", opc, c + 1, o, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [18:0] e;
    op = 7'b0100011; func3 = 3'b010; func7 = 7'h00; Zero = 0; ALUResult_sign = 0;
    exp_q.delete();
    build_expected(op, func3, func7, Zero, ALUResult_sign);
    for (int c = 0; c < 4; c++) begin
      e = exp_q.pop_front();
      @(negedge clk);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_mid_pre cyc%0d obs=%h exp=%h", c + 1, obs, e);
      end
      if (c < 3) begin
        @(posedge clk);
        #1;
      end
    end
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (obs !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_mid_drop obs=%h exp=%h", obs, 19'h0);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (obs !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_mid_hold obs=%h exp=%h", obs, 19'h0);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== v(1,0,1,0,0, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0)) begin
      n_fail++;
      $display("FAIL reset_mid_refetch obs=%h exp=%h", obs, v(1,0,1,0,0, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0));
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] e, o;
    for (int i = 0; i < 150; i++) begin
      logic [6:0] opc;
      opc = ($urandom_range(0, 9) == 0) ? 7'($urandom) : rand_legal_op();
      drive_instr(opc, 3'($urandom), 7'($urandom), 1'($urandom), 1'($urandom));
      for (int c = 0; exp_q.size() > 0; c++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_checks++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL b2b #%0d op=%b cyc%0d obs=%h exp=%h", i, opc, c + 1, o, e);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    op = '0; func3 = '0; func7 = '0; Zero = 1'b0; ALUResult_sign = 1'b0;
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_jumps();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Finite-state controller that sequences the RISC-V multi-cycle datapath, in which a single unified memory and a single ALU are shared across the cycles of each instruction. It consumes the decoded fields of the instruction register and the ALU flags, and drives every mux select and write enable of the datapath. It replaces the single-cycle `controller`, sitting beside `data_path` under the top level.

## Interface
- No parameters.
- `clk` input 1: the single clock; all state changes occur on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `op` input 7: IR[6:0].
- `func3` input 3: IR[14:12].
- `func7` input 7: IR[31:25]; only bit 5 is used.
- `Zero` input 1: ALU result == 0.
- `ALUResult_sign` input 1: ALU result bit 31.
- `PCWrite` output 1: PC register load enable.
- `AdrSrc` output 1: memory address select; 0 = PC, 1 = Result.
- `IRWrite` output 1: loads IR and OldPC.
- `MemWrite` output 1: memory write enable.
- `RegWrite` output 1: register file write enable.
- `ResultSrc` output 2: 00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt.
- `ALUSrcA` output 2: 00 = PC, 01 = OldPC, 10 = rs1 (A register).
- `ALUSrcB` output 2: 00 = rs2 (WriteData register), 01 = ImmExt, 10 = constant 4.
- `ALUControl` output 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `ImmSrc` output 3: 000 I, 001 S, 010 B, 011 J, 100 U.

## Operation
- Moore FSM. Outputs are decoded from the current state, plus `op`/`func3`/`func7`/flags where stated below. Any output not listed for a state is 0.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCWrite=1. Next state: DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (ALUOut = OldPC+imm). ImmSrc=011 if op=1101111, otherwise 010.
  - Next state by op: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI.
  - Any other op -> FETCH (executes as a NOP; PC has already advanced).
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. ImmSrc=000 for lw, 001 for sw. Next state: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: ResultSrc=00, AdrSrc=1. Next state: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next state: FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next state: FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUControl from the function decode below. Next state: ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, ALUControl from the function decode below (sub never selected). Next state: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next state: FETCH.
- Function decode:
  - func3 000 -> add; sub when op=0110011 and func7[5]=1.
  - func3 111 -> and; 110 -> or; 010 -> slt.
  - Any other func3 -> add.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite = taken, where taken = Zero for func3 000 (beq), !Zero for 001 (bne), ALUResult_sign for 100 (blt), !ALUResult_sign for 101 (bge), 0 for any other func3.
  - Next state: FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 (PC = target latched in DECODE; ALUOut becomes OldPC+4). Next state: ALUWB.
- JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, add. Next state: JALR2.
- JALR2: ResultSrc=00, PCWrite=1, ALUSrcA=01, ALUSrcB=10, add. Next state: ALUWB.
- LUI: ImmSrc=100, ResultSrc=11, RegWrite=1. Next state: FETCH.

## Timing
- `rst`=0 forces the state to FETCH immediately and asynchronously. While `rst`=0, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0 and all other outputs are 0.
- The first FETCH takes effect on the first rising edge after `rst` deasserts.
- Reset asserted mid-instruction abandons that instruction; no further writes occur.
- CPI, counted from FETCH to the next FETCH:
  - branch and lui: 3
  - R-type, I-type ALU, sw and jal: 4
  - lw and jalr: 5
- `op`/`func*` come from the IR, which is stable from DECODE onward. Inputs sampled in FETCH are don't-care.
- `Zero`/`ALUResult_sign` are used only in BRANCH, in the same cycle (combinational).
- Exactly one of the four write enables may be high per cycle, except FETCH, where PCWrite and IRWrite are both high.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with random inputs -> all outputs 0. After release, first cycle shows IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10.
- add then sub (op=0110011, func3=000, func7=0000000 then 0100000) -> EXECR ALUControl=000 then 001. RegWrite=1 exactly in cycle 4; 4 cycles each.
- lw/sw (op 0000011, 0100011) -> lw: AdrSrc=1 in cycle 4, RegWrite with ResultSrc=01 in cycle 5. sw: MemWrite=1 only in cycle 4, ImmSrc=001 in cycle 3.
- Branches: beq with Zero=1 -> PCWrite=1 in cycle 3; bne with Zero=1 -> PCWrite=0; blt with sign=1 -> taken; bge with sign=1 -> not taken. Each takes 3 cycles.
- jal/jalr/lui: jal -> DECODE ImmSrc=011, PCWrite in cycle 3, RegWrite in cycle 4. jalr -> PCWrite in cycle 4, RegWrite in cycle 5. lui -> ResultSrc=11, ImmSrc=100, RegWrite in cycle 3.
- Illegal op 1111111 -> DECODE returns to FETCH with no write enables. Assert `rst` during MEMWRITE -> MemWrite drops in the same cycle.
